multi_watchdog: RTL and testbench
=================================

Name: multi_watchdog

Overview:
Parametrised N-channel activity watchdog, the generalised successor to the single-channel watchdog.
- Each channel watches a CH_W-bit input slice; any change of the slice counts as a kick.
- Each channel raises a pre-timeout warning, a sticky expiry, and optionally a window (too-early kick) fault.
- Faults hold until software clears them. Sits between the top-level input pins and the status/LED outputs.

Parameters:
NUM_CH, 3, number of independent channels
CH_W, 8, width of each monitored input slice
CNT_W, 20, width of each channel's counter
TIMEOUT, 100000, idle clock edges after a kick before expiry; must satisfy 1 <= TIMEOUT <= 2^CNT_W-1
WARN_AT, 75000, idle edges after a kick before warn asserts; must satisfy 0 < WARN_AT < TIMEOUT
WINDOW_MIN, 0, minimum counter value for a legal kick; 0 disables window mode; must satisfy WINDOW_MIN < WARN_AT

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  reset, synchronous, active-low
data_in  input  NUM_CH*CH_W  monitored slices; channel i uses bits [i*CH_W +: CH_W]
ch_en  input  NUM_CH  per-channel enable, level
clear  input  NUM_CH  per-channel fault clear, sampled each edge
warn  output  NUM_CH  counter has reached WARN_AT since the last kick
expired  output  NUM_CH  sticky timeout fault
early_fault  output  NUM_CH  sticky window fault
any_fault  output  1  OR of all expired and early_fault bits (combinational from registers)
fault_count  output  8  saturating count of fault events, all channels

Behaviour:
Reset (rst_n=0 at an edge):
- All channels go to DISARMED; ref, counter, warn, expired, early_fault and fault_count all become 0.

Per-channel states: DISARMED, RUNNING, FAULT.

DISARMED:
- ch_en=1: ref <= slice, counter <= 0, go to RUNNING. Capturing the baseline is not a kick.
- ch_en=0: hold.

RUNNING, evaluated in priority order each edge:
1. ch_en=0: go to DISARMED; counter <= 0, warn <= 0.
2. Kick (slice != ref): ref <= slice.
   - WINDOW_MIN>0 and counter < WINDOW_MIN (pre-edge value): early_fault <= 1, warn <= 0, go to FAULT.
   - Otherwise: counter <= 0, warn <= 0.
3. No kick and counter == TIMEOUT-1: expired <= 1, warn <= 0, go to FAULT.
   - Result: expired rises exactly TIMEOUT edges after the kick edge.
4. No kick otherwise: counter <= counter+1; warn <= 1 when counter+1 >= WARN_AT.
   - Result: warn rises WARN_AT edges after the kick.

FAULT:
- counter and ref hold; warn=0. Kicks and ch_en are ignored.
- clear[i]=1: expired <= 0, early_fault <= 0, go to DISARMED. The channel re-arms on the next edge if ch_en=1.

Simultaneous events:
- Kick and timeout on the same edge: the kick wins and the counter resets. This does not apply if the kick is early.
- clear while RUNNING or DISARMED: no effect.

fault_count:
- Increments by the number of channels entering FAULT on that edge, saturating at 255.
- Cleared only by reset.

Channels are fully independent. Widths: counter compare is CNT_W unsigned; no wrap is possible given the parameter constraints.

Test Plan:
Bench parameters: NUM_CH=3, CH_W=8, CNT_W=8, TIMEOUT=20, WARN_AT=15, WINDOW_MIN=4.
1. Basic timeout: reset, ch_en=3'b001, hold data -> warn[0] rises 15 edges after enable; expired[0] and any_fault rise at edge 20; warn[0] drops; fault_count=1.
2. Periodic kicks: toggle slice 0 every 10 edges for 200 edges -> expired, early_fault and warn stay 0. Then kick at exactly edge 19 after the previous kick -> no expiry.
3. Window fault: kick slice 1 at counter=3 -> early_fault[1]=1, expired[1]=0. Kick at counter=4 -> legal.
4. Clear and re-arm: in FAULT assert clear[0] one cycle -> flags drop next edge. With ch_en=1 held, expired rises again 20 edges after re-arm.
5. Disable and simultaneity: drop ch_en mid-count -> no fault, counter resets. Channels 0 and 2 expire on the same edge -> fault_count +2. Force 300 faults -> fault_count=255.
6. Reset mid-operation: rst_n low for one edge while warn=1 and one channel in FAULT -> all outputs 0 on that edge.

Source files
------------

// File: rtl/multi_watchdog.sv
// N-channel activity watchdog: each channel watches a data slice, warns before
// timeout, and latches expiry / too-early-kick faults until software clears them.
module multi_watchdog #(
  parameter int NUM_CH     = 3,
  parameter int CH_W       = 8,
  parameter int CNT_W      = 20,
  parameter int TIMEOUT    = 100000,
  parameter int WARN_AT    = 75000,
  parameter int WINDOW_MIN = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CH*CH_W-1:0] data_in,
  input  logic [NUM_CH-1:0]      ch_en,
  input  logic [NUM_CH-1:0]      clear,
  output logic [NUM_CH-1:0]      warn,
  output logic [NUM_CH-1:0]      expired,
  output logic [NUM_CH-1:0]      early_fault,
  output logic                   any_fault,
  output logic [7:0]             fault_count
);

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    RUNNING  = 2'd1,
    FAULT    = 2'd2
  } ch_state_e;

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WARN_TH  = CNT_W'(WARN_AT);
  localparam bit               WIN_EN   = (WINDOW_MIN > 0);
  // Window test is written as cnt <= WINDOW_MIN-1 so a disabled window never
  // produces a constant unsigned "< 0" compare.
  localparam logic [CNT_W-1:0] WIN_LAST = WIN_EN ? CNT_W'(WINDOW_MIN - 1) : '0;

  ch_state_e        state_q [NUM_CH];
  ch_state_e        state_d [NUM_CH];
  logic [CH_W-1:0]  ref_q   [NUM_CH];
  logic [CH_W-1:0]  ref_d   [NUM_CH];
  logic [CNT_W-1:0] cnt_q   [NUM_CH];
  logic [CNT_W-1:0] cnt_d   [NUM_CH];
  logic [CH_W-1:0]  slice   [NUM_CH];

  logic [NUM_CH-1:0] warn_q, warn_d;
  logic [NUM_CH-1:0] exp_q, exp_d;
  logic [NUM_CH-1:0] early_q, early_d;
  logic [NUM_CH-1:0] enter_fault;
  logic [7:0]        fc_q, fc_d;
  logic [15:0]       n_enter;
  logic [15:0]       fc_sum;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slice
    assign slice[g] = data_in[g*CH_W +: CH_W];
  end

  always_comb begin
    warn_d      = warn_q;
    exp_d       = exp_q;
    early_d     = early_q;
    enter_fault = '0;
    for (int unsigned i = 0; i < unsigned'(NUM_CH); i++) begin
      state_d[i] = state_q[i];
      ref_d[i]   = ref_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        DISARMED: begin
          if (ch_en[i]) begin
            ref_d[i]   = slice[i];
            cnt_d[i]   = '0;
            state_d[i] = RUNNING;
          end
        end
        RUNNING: begin
          if (!ch_en[i]) begin
            state_d[i] = DISARMED;
            cnt_d[i]   = '0;
            warn_d[i]  = 1'b0;
          end else if (slice[i] != ref_q[i]) begin
            ref_d[i] = slice[i];
            if (WIN_EN && (cnt_q[i] <= WIN_LAST)) begin
              early_d[i]     = 1'b1;
              warn_d[i]      = 1'b0;
              state_d[i]     = FAULT;
              enter_fault[i] = 1'b1;
            end else begin
              cnt_d[i]  = '0;
              warn_d[i] = 1'b0;
            end
          end else if (cnt_q[i] == TO_LAST) begin
            exp_d[i]       = 1'b1;
            warn_d[i]      = 1'b0;
            state_d[i]     = FAULT;
            enter_fault[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
            if ((cnt_q[i] + CNT_W'(1)) >= WARN_TH) begin
              warn_d[i] = 1'b1;
            end
          end
        end
        FAULT: begin
          warn_d[i] = 1'b0;
          if (clear[i]) begin
            exp_d[i]   = 1'b0;
            early_d[i] = 1'b0;
            state_d[i] = DISARMED;
          end
        end
        default: begin
          state_d[i] = DISARMED;
          cnt_d[i]   = '0;
          warn_d[i]  = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    n_enter = '0;
    for (int unsigned i = 0; i < unsigned'(NUM_CH); i++) begin
      n_enter = n_enter + 16'(enter_fault[i]);
    end
    fc_sum = {8'h00, fc_q} + n_enter;
    fc_d   = (fc_sum > 16'd255) ? 8'hFF : fc_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < unsigned'(NUM_CH); i++) begin
        state_q[i] <= DISARMED;
        ref_q[i]   <= '0;
        cnt_q[i]   <= '0;
      end
      warn_q  <= '0;
      exp_q   <= '0;
      early_q <= '0;
      fc_q    <= '0;
    end else begin
      for (int unsigned i = 0; i < unsigned'(NUM_CH); i++) begin
        state_q[i] <= state_d[i];
        ref_q[i]   <= ref_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      warn_q  <= warn_d;
      exp_q   <= exp_d;
      early_q <= early_d;
      fc_q    <= fc_d;
    end
  end

  assign warn        = warn_q;
  assign expired     = exp_q;
  assign early_fault = early_q;
  assign any_fault   = (|exp_q) | (|early_q);
  assign fault_count = fc_q;

endmodule

// File: tb/tb_multi_watchdog.sv
// Directed bench for multi_watchdog with short timeouts (TIMEOUT=20, WARN_AT=15,
// WINDOW_MIN=4); expected values are hand-derived edge counts.
module tb_multi_watchdog;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] data_in;
  logic [2:0]  ch_en;
  logic [2:0]  clear;
  logic [2:0]  warn;
  logic [2:0]  expired;
  logic [2:0]  early_fault;
  logic        any_fault;
  logic [7:0]  fault_count;

  int checks = 0;
  int errors = 0;

  multi_watchdog #(
    .NUM_CH(3), .CH_W(8), .CNT_W(8), .TIMEOUT(20), .WARN_AT(15), .WINDOW_MIN(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .ch_en(ch_en), .clear(clear),
    .warn(warn), .expired(expired), .early_fault(early_fault),
    .any_fault(any_fault), .fault_count(fault_count)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; ch_en = '0; clear = '0; data_in = 24'h000000;
    tick(2);
    chk("rst_warn", 32'(warn), 0);
    chk("rst_exp", 32'(expired), 0);
    chk("rst_early", 32'(early_fault), 0);
    chk("rst_any", 32'(any_fault), 0);
    chk("rst_fc", 32'(fault_count), 0);
    rst_n = 1'b1;

    // Basic timeout on channel 0
    ch_en = 3'b001;
    tick(1);
    tick(14);
    chk("t1_warn_pre", 32'(warn), 0);
    tick(1);
    chk("t1_warn_15", 32'(warn), 32'b001);
    tick(4);
    chk("t1_exp_19", 32'(expired), 0);
    chk("t1_warn_19", 32'(warn), 32'b001);
    tick(1);
    chk("t1_exp_20", 32'(expired), 32'b001);
    chk("t1_any_20", 32'(any_fault), 1);
    chk("t1_warn_20", 32'(warn), 0);
    chk("t1_fc", 32'(fault_count), 1);

    // Kicks ignored while in FAULT
    data_in[7:0] = 8'h55;
    tick(3);
    chk("fault_hold_exp", 32'(expired), 32'b001);
    chk("fault_hold_fc", 32'(fault_count), 1);

    // Clear and re-arm with ch_en held
    clear = 3'b001;
    tick(1);
    clear = '0;
    chk("t4_clr_exp", 32'(expired), 0);
    chk("t4_clr_any", 32'(any_fault), 0);
    tick(1);
    tick(19);
    chk("t4_rearm_19", 32'(expired), 0);
    tick(1);
    chk("t4_rearm_20", 32'(expired), 32'b001);
    chk("t4_fc", 32'(fault_count), 2);
    clear = 3'b001;
    tick(1);
    clear = '0;
    tick(1);

    // Periodic kicks every 10 edges
    for (int k = 0; k < 20; k++) begin
      tick(9);
      data_in[7:0] = data_in[7:0] ^ 8'h01;
      tick(1);
      chk("t2_periodic", 32'({warn[0], expired[0], early_fault[0]}), 0);
    end
    tick(18);
    chk("t2_warn_18", 32'(warn), 32'b001);
    data_in[7:0] = data_in[7:0] ^ 8'h01;
    tick(1);
    chk("t2_kick19_exp", 32'(expired), 0);
    chk("t2_kick19_warn", 32'(warn), 0);
    tick(19);
    data_in[7:0] = data_in[7:0] ^ 8'h01;
    tick(1);
    chk("t2_simul_exp", 32'(expired), 0);
    chk("t2_simul_warn", 32'(warn), 0);
    tick(19);
    chk("t2_after_19", 32'(expired), 0);
    tick(1);
    chk("t2_after_20", 32'(expired), 32'b001);
    chk("t2_fc", 32'(fault_count), 3);
    clear = 3'b001; ch_en = '0;
    tick(1);
    clear = '0;

    // Window fault on channel 1
    ch_en = 3'b010;
    tick(1);
    tick(3);
    data_in[15:8] = data_in[15:8] ^ 8'h10;
    tick(1);
    chk("t3_early", 32'(early_fault), 32'b010);
    chk("t3_exp", 32'(expired), 0);
    chk("t3_any", 32'(any_fault), 1);
    chk("t3_fc", 32'(fault_count), 4);
    clear = 3'b010;
    tick(1);
    clear = '0;
    chk("t3_clr", 32'(early_fault), 0);
    tick(1);
    tick(4);
    data_in[15:8] = data_in[15:8] ^ 8'h10;
    tick(1);
    chk("t3_legal", 32'(early_fault), 0);
    chk("t3_legal_fc", 32'(fault_count), 4);
    ch_en = '0;
    tick(1);

    // Disable mid-count resets the counter
    ch_en = 3'b010;
    tick(1);
    tick(17);
    chk("t5_warn", 32'(warn), 32'b010);
    ch_en = '0;
    tick(1);
    chk("t5_dis_warn", 32'(warn), 0);
    ch_en = 3'b010;
    tick(1);
    tick(19);
    chk("t5_rst_cnt", 32'(expired), 0);
    tick(1);
    chk("t5_exp", 32'(expired), 32'b010);
    chk("t5_fc", 32'(fault_count), 5);
    clear = 3'b010; ch_en = '0;
    tick(1);
    clear = '0;

    // Channels 0 and 2 expire on the same edge
    ch_en = 3'b101;
    tick(1);
    tick(19);
    chk("t5_pair_19", 32'(expired), 0);
    tick(1);
    chk("t5_pair_exp", 32'(expired), 32'b101);
    chk("t5_pair_fc", 32'(fault_count), 7);

    // Saturation: repeated early faults on every channel
    ch_en = 3'b111; clear = 3'b111;
    for (int k = 0; k < 400; k++) begin
      data_in = ~data_in;
      tick(1);
    end
    chk("t5_sat", 32'(fault_count), 255);
    ch_en = '0;
    tick(2);
    clear = '0;
    tick(1);
    chk("t5_sat_any", 32'(any_fault), 0);

    // Reset while one channel warns and another is faulted
    ch_en = 3'b100;
    tick(1);
    tick(5);
    ch_en = 3'b101;
    tick(1);
    tick(15);
    chk("t6_pre_warn", 32'(warn), 32'b001);
    chk("t6_pre_exp", 32'(expired), 32'b100);
    rst_n = 1'b0;
    tick(1);
    chk("t6_warn", 32'(warn), 0);
    chk("t6_exp", 32'(expired), 0);
    chk("t6_early", 32'(early_fault), 0);
    chk("t6_any", 32'(any_fault), 0);
    chk("t6_fc", 32'(fault_count), 0);
    rst_n = 1'b1; ch_en = '0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
